uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_cfg_if.sv | 13 +
 rtl/baud_tick_gen.sv | 36 +++
 rtl/uart_tx_cfg.sv | 156 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the frame FSM state encoding,
// kept here so a future receiver can reuse them.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-write handshake and serial outputs of the UART transmitter.
interface uart_tx_cfg_if;

  logic [8:0] din;
  logic       wen;
  logic       ready;
  logic       tx_out;
  logic       tx_done;

  modport master (output din, output wen, input ready, input tx_out, input tx_done);
  modport slave  (input din, input wen, output ready, output tx_out, output tx_done);

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick on the
// last count. restart holds the count at zero so the next period starts aligned.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data LSB first, optional
// parity, STOP_BITS stop bits, with a ready/wen byte handshake.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_cfg_if.slave  bus
);

  localparam int                 IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic               STOP_LAST = (STOP_BITS == 2);

  uart_state_e          state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_out_q, tx_out_d;
  logic                 ready_q, ready_d;
  logic                 tx_done_q, tx_done_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tick;
  logic                 restart;
  logic                 accept;
  logic                 unused_din;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY == PAR_ODD);
  endfunction

  // Timer sits at zero while idle, so the accept edge starts a clean start bit.
  assign restart    = (state_q == ST_IDLE);
  assign accept     = ready_q && bus.wen;
  assign unused_din = ^bus.din;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_out_d   = tx_out_q;
    ready_d    = ready_q;
    tx_done_d  = 1'b0;
    shreg_d    = shreg_q;
    par_d      = par_q;

    case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        if (accept) begin
          shreg_d    = bus.din[DATA_BITS-1:0];
          par_d      = parity_bit(bus.din[DATA_BITS-1:0]);
          ready_d    = 1'b0;
          tx_out_d   = 1'b0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_out_d  = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == IDX_LAST) begin
            if (PARITY != PAR_NONE) begin
              tx_out_d = par_q;
              state_d  = ST_PAR;
            end else begin
              tx_out_d   = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_out_d  = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          tx_out_d   = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_idx_q == STOP_LAST) begin
            ready_d    = 1'b1;
            tx_done_d  = 1'b1;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        tx_out_d = 1'b1;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_out_q   <= 1'b1;
      ready_q    <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_out_q   <= tx_out_d;
      ready_q    <= ready_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Latched byte and parity carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  assign bus.ready   = ready_q;
  assign bus.tx_out  = tx_out_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four configurations at CLKS_PER_BIT=4, with
// hand-written expected bit sequences checked cycle by cycle by a monitor.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_cfg_if bus0();
  uart_tx_cfg_if bus1();
  uart_tx_cfg_if bus2();
  uart_tx_cfg_if bus3();

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));
  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [8:0] din_s [4];
  logic [3:0] wen_s;

  assign bus0.din = din_s[0];
  assign bus1.din = din_s[1];
  assign bus2.din = din_s[2];
  assign bus3.din = din_s[3];
  assign bus0.wen = wen_s[0];
  assign bus1.wen = wen_s[1];
  assign bus2.wen = wen_s[2];
  assign bus3.wen = wen_s[3];

  wire [3:0] rdy_v  = {bus3.ready,   bus2.ready,   bus1.ready,   bus0.ready};
  wire [3:0] tx_v   = {bus3.tx_out,  bus2.tx_out,  bus1.tx_out,  bus0.tx_out};
  wire [3:0] done_v = {bus3.tx_done, bus2.tx_done, bus1.tx_done, bus0.tx_done};

  int   sel = 0;
  logic mon_tx, mon_rdy, mon_done;
  assign mon_tx   = tx_v[sel[1:0]];
  assign mon_rdy  = rdy_v[sel[1:0]];
  assign mon_done = done_v[sel[1:0]];

  // bits holds the frame in send order: bits[nbits-1] is the start bit.
  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          chk_gap;
    int          tag;
  } frame_t;

  typedef enum int {M_IDLE, M_FRAME, M_DONE, M_RST} mon_e;

  frame_t     exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  mon_e       mode  = M_IDLE;
  frame_t     cur;
  int         c;
  int         idle_cnt = 0;
  bit         bad;
  bit         spur = 0;
  logic [2:0] act, req;

  task automatic frame_cycle();
    logic e;
    e = cur.bits[4'(cur.nbits - 1 - (c / CPB))];
    if (!bad && (mon_tx !== e || mon_rdy !== 1'b0 || mon_done !== 1'b0)) begin
      bad = 1'b1;
      act = {mon_rdy, mon_done, mon_tx};
      req = {2'b00, e};
    end
    if ((c % CPB) == CPB - 1) begin
      n_vec++;
      if (bad) begin
        n_err++;
        $display("FAIL frame%0d bit%0d: {ready,done,tx} got %b want %b", cur.tag, c / CPB, act, req);
      end
      bad = 1'b0;
    end
    c++;
    if (c == cur.nbits * CPB) mode = M_DONE;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        M_RST: begin
          n_vec++;
          if (mon_tx !== 1'b1 || mon_rdy !== 1'b1 || mon_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state ch%0d: {ready,done,tx} got %b%b%b want 101",
                     sel, mon_rdy, mon_done, mon_tx);
          end
          mode     = M_IDLE;
          idle_cnt = 0;
        end
        M_IDLE: begin
          if (mon_done !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_done ch%0d: tx_done got %b want 0", sel, mon_done);
          end
          if (spur) begin
            if (mon_tx === 1'b1) spur = 1'b0;
          end else if (mon_tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              spur = 1'b1;
              $display("FAIL unexpected_start ch%0d: tx got 0 want 1", sel);
            end else begin
              cur = exp_q.pop_front();
              if (cur.chk_gap) begin
                n_vec++;
                if (idle_cnt != 0) begin
                  n_err++;
                  $display("FAIL frame%0d gap: idle cycles got %0d want 0", cur.tag, idle_cnt);
                end
              end
              c    = 0;
              bad  = 1'b0;
              mode = M_FRAME;
              frame_cycle();
            end
          end else begin
            idle_cnt++;
          end
        end
        M_FRAME: frame_cycle();
        M_DONE: begin
          n_vec++;
          if (mon_done !== 1'b1 || mon_rdy !== 1'b1 || mon_tx !== 1'b1) begin
            n_err++;
            $display("FAIL frame%0d end: {ready,done,tx} got %b%b%b want 111",
                     cur.tag, mon_rdy, mon_done, mon_tx);
          end
          mode     = M_IDLE;
          idle_cnt = 0;
        end
        default: mode = M_IDLE;
      endcase
      if (rst) mode = M_RST;
    end
  end

  task automatic send(input int ch, input logic [8:0] d, input logic [15:0] bits,
                      input int nbits, input bit gap, input int tag);
    frame_t f;
    bit     got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rdy_v[ch] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout frame%0d: ready got 0 want 1", tag);
      return;
    end
    f.bits    = bits;
    f.nbits   = nbits;
    f.chk_gap = gap;
    f.tag     = tag;
    exp_q.push_back(f);
    din_s[ch] = d;
    wen_s[ch] = 1'b1;
    @(posedge clk);
    #1;
    wen_s[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mode == M_IDLE) idle = 1'b1;
    end
    if (!idle) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout ch%0d: pending frames got %0d want 0", sel, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got %0t want < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) din_s[i] = 9'h000;
    wen_s = 4'b0000;
    sel   = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 8N1: 0xA5, then back-to-back 0x55 and 0x0F with stray wen pulses mid-frame
    send(0, 9'h0A5, 16'(10'b0101001011), 10, 1'b0, 1);
    send(0, 9'h055, 16'(10'b0101010101), 10, 1'b1, 2);
    repeat (5) @(posedge clk);
    #1 din_s[0] = 9'h000; wen_s[0] = 1'b1;
    @(posedge clk);
    #1 wen_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 din_s[0] = 9'h1FF; wen_s[0] = 1'b1;
    @(posedge clk);
    #1 wen_s[0] = 1'b0;
    send(0, 9'h00F, 16'(10'b0111100001), 10, 1'b1, 3);
    wait_idle();

    // Reset during data bit 3 aborts the frame; the next byte must go out intact
    send(0, 9'h0A5, 16'(10'b0101001011), 10, 1'b0, 4);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    send(0, 9'h03C, 16'(10'b0001111001), 10, 1'b0, 5);
    wait_idle();

    sel = 1;
    send(1, 9'h0A5, 16'(11'b01010010101), 11, 1'b0, 6);
    send(1, 9'h007, 16'(11'b01110000011), 11, 1'b1, 7);
    wait_idle();

    sel = 2;
    send(2, 9'h000, 16'(11'b00000000011), 11, 1'b0, 8);
    send(2, 9'h001, 16'(11'b01000000001), 11, 1'b1, 9);
    wait_idle();

    sel = 3;
    send(3, 9'h1FF, 16'(10'b0111111111), 10, 1'b0, 10);
    send(3, 9'h02A, 16'(10'b0010101011), 10, 1'b1, 11);
    send(3, 9'h180, 16'(10'b0000000011), 10, 1'b1, 12);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
